// File: rtl/nios_qsys_cpu_0_oci_dct_packer.sv
// rtl/nios_qsys_cpu_0_oci_dct_packer.sv - packs 2-bit trace items into 15-slot frames; DCT_PACKER_STATS_EN builds frames_sent
module nios_qsys_cpu_0_oci_dct_packer #(
    parameter int FLUSH_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        item_valid,
    input  logic [1:0]  item_data,
    output logic        item_ready,
    input  logic        flush,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic [15:0] frames_sent
);

    localparam int IDLE_W = (FLUSH_TIMEOUT < 2) ? 1 : $clog2(FLUSH_TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(FLUSH_TIMEOUT);

    logic [29:0]       acc_q;
    logic [3:0]        acc_cnt_q;
    logic [IDLE_W-1:0] idle_q;
    logic              flush_pending_q;
    logic              frame_valid_q;
    logic [29:0]       dct_buffer_q;
    logic [3:0]        dct_count_q;

    logic              accept;
    logic              timeout_hit;
    logic              close_req;
    logic              transfer;
    logic [29:0]       acc_base;
    logic [3:0]        cnt_base;
    logic [29:0]       acc_next;
    logic [3:0]        cnt_next;
    logic [IDLE_W-1:0] idle_next;
    logic              flush_pending_next;

    assign item_ready  = reset_n && (acc_cnt_q != 4'd15);
    assign accept      = item_valid && item_ready;
    assign timeout_hit = (FLUSH_TIMEOUT != 0) && (idle_q == IDLE_MAX);
    assign close_req   = (acc_cnt_q == 4'd15) || flush_pending_q || timeout_hit;
    assign transfer    = close_req && (acc_cnt_q != 4'd0) && (!frame_valid_q || frame_ready);

    // A transfer empties the accumulator first, so a same-cycle item lands in slot 0.
    always_comb begin
        acc_base = transfer ? 30'd0 : acc_q;
        cnt_base = transfer ? 4'd0 : acc_cnt_q;
        acc_next = acc_base;
        cnt_next = cnt_base;
        if (accept) begin
            for (int k = 0; k < 15; k++) begin
                if (cnt_base == 4'(k)) begin
                    acc_next[2*k +: 2] = item_data;
                end
            end
            cnt_next = cnt_base + 4'd1;
        end
    end

    always_comb begin
        idle_next = idle_q;
        if (accept || transfer) begin
            idle_next = '0;
        end else if ((acc_cnt_q != 4'd0) && (idle_q != IDLE_MAX)) begin
            idle_next = idle_q + IDLE_W'(1);
        end
    end

    // A flush only sticks when something will be left to emit.
    always_comb begin
        flush_pending_next = transfer ? 1'b0 : flush_pending_q;
        if (flush && (cnt_next != 4'd0)) begin
            flush_pending_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q           <= '0;
            acc_cnt_q       <= '0;
            idle_q          <= '0;
            flush_pending_q <= 1'b0;
        end else begin
            acc_q           <= acc_next;
            acc_cnt_q       <= cnt_next;
            idle_q          <= idle_next;
            flush_pending_q <= flush_pending_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_valid_q <= 1'b0;
            dct_buffer_q  <= '0;
            dct_count_q   <= '0;
        end else if (transfer) begin
            frame_valid_q <= 1'b1;
            dct_buffer_q  <= acc_q;
            dct_count_q   <= acc_cnt_q;
        end else if (frame_valid_q && frame_ready) begin
            frame_valid_q <= 1'b0;
            dct_buffer_q  <= '0;
            dct_count_q   <= '0;
        end
    end

    assign frame_valid = frame_valid_q;
    assign dct_buffer  = dct_buffer_q;
    assign dct_count   = dct_count_q;

`ifdef DCT_PACKER_STATS_EN
    logic [15:0] frames_sent_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frames_sent_q <= '0;
        end else if (transfer) begin
            frames_sent_q <= frames_sent_q + 16'd1;
        end
    end

    assign frames_sent = frames_sent_q;
`else
    assign frames_sent = 16'd0;
`endif

endmodule

// File: tb/tb_nios_qsys_cpu_0_oci_dct_packer.sv
// tb/tb_nios_qsys_cpu_0_oci_dct_packer.sv - directed self-checking bench for the trace item packer
module tb_nios_qsys_cpu_0_oci_dct_packer;

`ifdef DCT_PACKER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        item_valid;
    logic [1:0]  item_data;
    logic        item_ready;
    logic        flush;
    logic        frame_valid;
    logic        frame_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic [15:0] frames_sent;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    nios_qsys_cpu_0_oci_dct_packer #(.FLUSH_TIMEOUT(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .item_valid  (item_valid),
        .item_data   (item_data),
        .item_ready  (item_ready),
        .flush       (flush),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .dct_buffer  (dct_buffer),
        .dct_count   (dct_count),
        .frames_sent (frames_sent)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] code);
        int n = 0;
        item_valid = 1'b1;
        item_data  = code;
        while (!item_ready && n < 50) begin
            tick();
            n++;
        end
        if (!item_ready) check("push_stall", 32'd0, 32'd1);
        else tick();
        item_valid = 1'b0;
    endtask

    initial begin
        logic [29:0] e1;
        logic [29:0] e2;
        logic [1:0]  code;
        int          n;

        reset_n     = 1'b0;
        item_valid  = 1'b0;
        item_data   = 2'd0;
        flush       = 1'b0;
        frame_ready = 1'b0;
        tick();
        tick();
        check("rst_item_ready", 32'(item_ready), 32'd0);
        check("rst_frame_valid", 32'(frame_valid), 32'd0);
        check("rst_dct_count", 32'(dct_count), 32'd0);
        check("rst_frames_sent", 32'(frames_sent), 32'd0);
        reset_n = 1'b1;
        #1;
        check("rst_release_ready", 32'(item_ready), 32'd1);

        // 15 items of 01: full frame one cycle after the last accept
        frame_ready = 1'b1;
        for (int i = 0; i < 15; i++) push(2'b01);
        check("full_not_early", 32'(frame_valid), 32'd0);
        check("full_ready_low", 32'(item_ready), 32'd0);
        tick();
        check("full_valid", 32'(frame_valid), 32'd1);
        check("full_buffer", 32'(dct_buffer), 32'h15555555);
        check("full_count", 32'(dct_count), 32'd15);
        check("full_ready_back", 32'(item_ready), 32'd1);
        tick();
        check("full_consumed_valid", 32'(frame_valid), 32'd0);
        check("full_consumed_buffer", 32'(dct_buffer), 32'd0);
        check("full_consumed_count", 32'(dct_count), 32'd0);

        // items 3,2,1 then flush
        push(2'd3);
        push(2'd2);
        push(2'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_not_early", 32'(frame_valid), 32'd0);
        tick();
        check("flush_valid", 32'(frame_valid), 32'd1);
        check("flush_buffer", 32'(dct_buffer), 32'h0000001B);
        check("flush_count", 32'(dct_count), 32'd3);
        tick();
        tick();
        check("flush_single_frame", 32'(frame_valid), 32'd0);

        // back-pressure: 30 items with consumer stalled
        frame_ready = 1'b0;
        e1 = '0;
        e2 = '0;
        for (int i = 0; i < 30; i++) begin
            code = 2'(i % 4);
            if (i < 15) e1[2*i +: 2] = code;
            else e2[2*(i-15) +: 2] = code;
            push(code);
        end
        check("bp_ready_low", 32'(item_ready), 32'd0);
        check("bp_valid", 32'(frame_valid), 32'd1);
        check("bp_buffer1", 32'(dct_buffer), 32'(e1));
        check("bp_count1", 32'(dct_count), 32'd15);
        tick();
        tick();
        tick();
        check("bp_hold_buffer", 32'(dct_buffer), 32'(e1));
        check("bp_hold_ready", 32'(item_ready), 32'd0);
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        check("bp_valid2", 32'(frame_valid), 32'd1);
        check("bp_buffer2", 32'(dct_buffer), 32'(e2));
        check("bp_count2", 32'(dct_count), 32'd15);
        check("bp_ready_again", 32'(item_ready), 32'd1);
        frame_ready = 1'b1;
        tick();
        check("bp_drained", 32'(frame_valid), 32'd0);

        // idle timeout of 8 cycles
        push(2'b10);
        n = 0;
        while (!frame_valid && n < 20) begin
            tick();
            n++;
        end
        check("to_latency", 32'(n), 32'd9);
        check("to_buffer", 32'(dct_buffer), 32'h2);
        check("to_count", 32'(dct_count), 32'd1);
        tick();
        check("to_consumed", 32'(frame_valid), 32'd0);
        check("fs_before_reset", 32'(frames_sent), STATS ? 32'd5 : 32'd0);

        // partial frame discarded by reset, empty flush emits nothing
        for (int i = 0; i < 7; i++) push(2'(i % 4));
        reset_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(item_ready), 32'd0);
        tick();
        reset_n = 1'b1;
        #1;
        check("post_rst_ready", 32'(item_ready), 32'd1);
        check("post_rst_valid", 32'(frame_valid), 32'd0);
        check("post_rst_count", 32'(dct_count), 32'd0);
        check("post_rst_frames", 32'(frames_sent), 32'd0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (frame_valid) n++;
        end
        check("rst_no_frame", 32'(n), 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (frame_valid) n++;
        end
        check("empty_flush_no_frame", 32'(n), 32'd0);

        // three flushed frames for the statistics counter
        for (int f = 0; f < 3; f++) begin
            push(2'(f + 1));
            flush = 1'b1;
            tick();
            flush = 1'b0;
            tick();
            check("stat_frame_count", 32'(dct_count), 32'd1);
            check("stat_frame_buffer", 32'(dct_buffer), 32'(f + 1));
            tick();
        end
        check("stat_frames_sent", 32'(frames_sent), STATS ? 32'd3 : 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nios_qsys_cpu_0_oci_dct_packer.md
NIOS_QSYS_CPU_0_OCI_DCT_PACKER -- requirements
Module: nios_qsys_cpu_0_oci_dct_packer

Interface
REQ-001 SHALL have parameter FLUSH_TIMEOUT, default 64: the number of idle cycles before a partial frame is auto-flushed; 0 disables auto-flush.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port item_valid  input  1  a trace item is offered.
REQ-005 SHALL have port item_data  input  2  trace item code.
REQ-006 SHALL have port item_ready  output  1  packer accepts an item this cycle.
REQ-007 SHALL have port flush  input  1  single-cycle request to close the partial frame.
REQ-008 SHALL have port frame_valid  output  1  dct_buffer/dct_count hold a frame.
REQ-009 SHALL have port frame_ready  input  1  consumer takes the frame.
REQ-010 SHALL have port dct_buffer  output  30  packed items: item k at bits [2k+1:2k].
REQ-011 SHALL have port dct_count  output  4  number of valid items in dct_buffer.
REQ-012 SHALL have port frames_sent  output  16  frame counter (see Configuration).

Function
REQ-013 SHALL accept an item when item_valid && item_ready, writing it at slot acc_cnt of a 30-bit accumulator and incrementing acc_cnt (0..15).
REQ-014 SHALL drive item_ready = 1 iff reset_n is high and acc_cnt < 15.
REQ-015 SHALL raise a close request when any of these holds: acc_cnt==15; flush_pending; idle_cnt==FLUSH_TIMEOUT with FLUSH_TIMEOUT != 0.
REQ-016 SHALL transfer on close request && acc_cnt != 0 && (!frame_valid || frame_ready), loading dct_buffer with the accumulator (unused upper bits zero) and dct_count with acc_cnt, and asserting frame_valid the next cycle.
REQ-017 SHALL place an item accepted in the same cycle as a transfer at slot 0 of the fresh accumulator (acc_cnt becomes 1).
REQ-018 SHALL hold frame_valid, dct_buffer and dct_count stable until frame_ready; frame_valid && frame_ready without a transfer clears frame_valid, dct_buffer and dct_count to 0.
REQ-019 SHALL set flush_pending on flush and clear it on transfer; a flush with acc_cnt==0 and no accept that cycle emits no frame and leaves flush_pending clear.
REQ-020 SHALL increment idle_cnt (saturating) each cycle with acc_cnt != 0 and no accept, and clear it on accept or transfer.
REQ-021 SHALL keep the accumulator and stall item_ready when acc_cnt==15 and the output is occupied; no item is ever dropped or overwritten.

Reset
REQ-022 SHALL, while reset_n is low at a clk edge, clear the accumulator, acc_cnt, idle_cnt, flush_pending, frame_valid, dct_buffer, dct_count and frames_sent to 0; a partial frame is discarded and not emitted.
REQ-023 SHALL drive item_ready 0 during reset and 1 on the first cycle after reset_n rises.

Configuration
REQ-024 SHALL, with macro DCT_PACKER_STATS_EN defined, increment frames_sent (wrapping 16'hFFFF -> 0) on every transfer; without the macro, frames_sent SHALL be constant 0 and the counter SHALL not be built.

Verification
REQ-025 SHALL cover: 15 items of code 2'b01 with frame_ready=1 -> frame_valid one cycle after the 15th accept, dct_buffer=30'h15555555, dct_count=15.
REQ-026 SHALL cover: items 3, 2, 1, then flush -> dct_buffer=30'h0000001B, dct_count=3.
REQ-027 SHALL cover: frame_ready=0 with 30 items offered -> item_ready low after the 30th accept; frame_ready=1 for one cycle -> second frame loaded, item_ready high again.
REQ-028 SHALL cover: FLUSH_TIMEOUT=8, one item 2'b10, then idle -> frame dct_count=1, dct_buffer=30'h2 after 8 idle cycles.
REQ-029 SHALL cover: 7 items, then reset_n low for 1 cycle -> no frame, dct_count=0, frame_valid=0; flush with an empty accumulator -> no frame.
REQ-030 SHALL cover: with DCT_PACKER_STATS_EN, 3 frames -> frames_sent=3; without it -> frames_sent=0.
